// File: rtl/l2_cache_control.sv
// L2 cache sequencing FSM: hit check, pseudo-LRU victim selection,
// dirty write-back, line allocation from pmem, and hit/miss statistics.
module l2_cache_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arb_read,
    input  logic             arb_write,
    output logic             arb_resp,
    input  logic [3:0]       hit,
    input  logic [3:0]       dirty,
    input  logic [2:0]       LRU_out,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             write_back_bit,
    output logic [1:0]       way_sel,
    output logic             load_data,
    output logic             data_sel,
    output logic             load_tag,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             clear_dirty,
    output logic             lru_update,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] victim_way;
    logic       alloc_done;

    logic       req;
    logic       is_write;
    logic       any_hit;
    logic [1:0] hit_way;
    logic [1:0] lru_victim;
    logic       hit_det;
    logic       miss_det;
    logic       fill_done;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req       = arb_read | arb_write;
    assign is_write  = arb_write;
    assign any_hit   = |hit;
    assign hit_det   = (state == IDLE) && req && any_hit;
    assign miss_det  = (state == IDLE) && req && !any_hit;
    assign fill_done = (state == ALLOCATE) && pmem_resp;

    // Lowest-numbered matching way wins when several tags report a hit.
    always_comb begin
        hit_way = 2'd0;
        if (hit[0])      hit_way = 2'd0;
        else if (hit[1]) hit_way = 2'd1;
        else if (hit[2]) hit_way = 2'd2;
        else if (hit[3]) hit_way = 2'd3;
    end

    // Pseudo-LRU tree decode: bit0 picks the half, bit1/bit2 the way within it.
    always_comb begin
        lru_victim = 2'd0;
        case (LRU_out)
            3'b000, 3'b100: lru_victim = 2'd0;
            3'b010, 3'b110: lru_victim = 2'd1;
            3'b001, 3'b011: lru_victim = 2'd2;
            default:        lru_victim = 2'd3;
        endcase
    end

    // State, latched victim, and the flag marking the cycle right after a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            victim_way <= 2'd0;
            alloc_done <= 1'b0;
        end else begin
            state      <= state_next;
            alloc_done <= fill_done;
            if (miss_det) begin
                victim_way <= lru_victim;
            end
        end
    end

    // Next-state and Mealy strobe decode; every strobe defaults low.
    always_comb begin
        state_next     = state;
        arb_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        write_back_bit = 1'b0;
        way_sel        = 2'd0;
        load_data      = 1'b0;
        data_sel       = 1'b0;
        load_tag       = 1'b0;
        set_valid      = 1'b0;
        set_dirty      = 1'b0;
        clear_dirty    = 1'b0;
        lru_update     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (any_hit) begin
                        arb_resp   = 1'b1;
                        lru_update = 1'b1;
                        way_sel    = hit_way;
                        if (is_write) begin
                            load_data = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else if (dirty[lru_victim]) begin
                        state_next = WRITE_BACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                pmem_write     = 1'b1;
                write_back_bit = 1'b1;
                way_sel        = victim_way;
                if (pmem_resp) begin
                    clear_dirty = 1'b1;
                    state_next  = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim_way;
                if (pmem_resp) begin
                    load_data   = 1'b1;
                    data_sel    = 1'b1;
                    load_tag    = 1'b1;
                    set_valid   = 1'b1;
                    clear_dirty = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Statistics: the re-check hit that follows a fill is not a real hit.
    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_det && !alloc_done) begin
                hit_count <= sat_inc(hit_count);
            end
            if (miss_det) begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end

endmodule

// File: tb/tb_l2_cache_control.sv
// Scoreboard bench for l2_cache_control: randomized requests against a
// transaction-level model of the miss/hit sequencing and statistics.
module tb_l2_cache_control;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk;
    logic             reset;
    logic             arb_read;
    logic             arb_write;
    logic             arb_resp;
    logic [3:0]       hit;
    logic [3:0]       dirty;
    logic [2:0]       LRU_out;
    logic             pmem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             write_back_bit;
    logic [1:0]       way_sel;
    logic             load_data;
    logic             data_sel;
    logic             load_tag;
    logic             set_valid;
    logic             set_dirty;
    logic             clear_dirty;
    logic             lru_update;
    logic             clr_stats;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    l2_cache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .arb_read(arb_read), .arb_write(arb_write), .arb_resp(arb_resp),
        .hit(hit), .dirty(dirty), .LRU_out(LRU_out),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .write_back_bit(write_back_bit), .way_sel(way_sel),
        .load_data(load_data), .data_sel(data_sel), .load_tag(load_tag),
        .set_valid(set_valid), .set_dirty(set_dirty), .clear_dirty(clear_dirty),
        .lru_update(lru_update), .clr_stats(clr_stats),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected events: 0 = request response, 1 = write-back done, 2 = fill done
    typedef struct {
        int               kind;
        logic [1:0]       way;
        bit               wr;
        bit               chk;
        logic [CNT_W-1:0] eh;
        logic [CNT_W-1:0] em;
    } exp_t;

    exp_t             q[$];
    int               tests = 0;
    int               fails = 0;
    bit               mon_en = 1'b0;
    bit               cnt_pending = 1'b0;
    logic [CNT_W-1:0] pend_h;
    logic [CNT_W-1:0] pend_m;
    logic [CNT_W-1:0] model_hit = '0;
    logic [CNT_W-1:0] model_miss = '0;

    task automatic check(input string name, input bit ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Victim chosen by the pseudo-LRU bits of the set.
    function automatic logic [1:0] victim_of(input logic [2:0] l);
        case (l)
            3'b000, 3'b100: return 2'd0;
            3'b010, 3'b110: return 2'd1;
            3'b001, 3'b011: return 2'd2;
            default:        return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] lowest_way(input logic [3:0] h);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 3; i >= 0; i--) if (h[i]) w = 2'(i);
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + CNT_W'(1);
    endfunction

    // Monitor: pops an expectation whenever the DUT completes an event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (cnt_pending) begin
                    cnt_pending = 1'b0;
                    check("counters", hit_count == pend_h && miss_count == pend_m,
                          $sformatf("hit_count=%0d miss_count=%0d required %0d/%0d",
                                    hit_count, miss_count, pend_h, pend_m));
                end
                if (arb_resp || (pmem_resp && (pmem_read || pmem_write))) begin
                    if (q.size() == 0) begin
                        check("unexpected_event", 1'b0,
                              $sformatf("arb_resp=%0b pmem_read=%0b pmem_write=%0b with nothing expected",
                                        arb_resp, pmem_read, pmem_write));
                    end else begin
                        e = q.pop_front();
                        if (e.kind == 0) begin
                            check("resp", arb_resp && way_sel == e.way && lru_update &&
                                  load_data == e.wr && set_dirty == e.wr && !data_sel &&
                                  !load_tag && !pmem_read && !pmem_write,
                                  $sformatf("resp=%0b way=%0d lru=%0b ld=%0b sd=%0b ds=%0b lt=%0b required way=%0d wr=%0b",
                                            arb_resp, way_sel, lru_update, load_data, set_dirty,
                                            data_sel, load_tag, e.way, e.wr));
                        end else if (e.kind == 1) begin
                            check("writeback", pmem_write && !pmem_read && write_back_bit &&
                                  way_sel == e.way && clear_dirty && !load_data && !arb_resp,
                                  $sformatf("pw=%0b pr=%0b wbb=%0b way=%0d cd=%0b ld=%0b required way=%0d",
                                            pmem_write, pmem_read, write_back_bit, way_sel,
                                            clear_dirty, load_data, e.way));
                        end else begin
                            check("fill", pmem_read && !pmem_write && !write_back_bit &&
                                  way_sel == e.way && load_data && data_sel && load_tag &&
                                  set_valid && clear_dirty && !arb_resp,
                                  $sformatf("pr=%0b wbb=%0b way=%0d ld=%0b ds=%0b lt=%0b sv=%0b cd=%0b required way=%0d",
                                            pmem_read, write_back_bit, way_sel, load_data,
                                            data_sel, load_tag, set_valid, clear_dirty, e.way));
                        end
                        if (e.chk) begin
                            cnt_pending = 1'b1;
                            pend_h      = e.eh;
                            pend_m      = e.em;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resync();
        q.delete();
        cnt_pending = 1'b0;
        arb_read  = 1'b0;
        arb_write = 1'b0;
        pmem_resp = 1'b0;
        reset     = 1'b1;
        tick();
        reset      = 1'b0;
        model_hit  = '0;
        model_miss = '0;
    endtask

    task automatic push(input int k, input logic [1:0] w, input bit wr, input bit chk);
        exp_t e;
        e.kind = k; e.way = w; e.wr = wr; e.chk = chk;
        e.eh = model_hit; e.em = model_miss;
        q.push_back(e);
    endtask

    // One arbiter request from presentation to response (or abandonment).
    task automatic do_txn(input bit wr, input bit rd_too, input logic [3:0] hv,
                          input logic [3:0] dv, input logic [2:0] lv,
                          input bit withdraw, input int dly);
        logic [1:0] v;
        int         phases;
        int         n;
        bit         timed_out;
        timed_out = 1'b0;
        if (hv != 4'd0) begin
            model_hit = sat(model_hit);
            push(0, lowest_way(hv), wr, 1'b1);
        end else begin
            v          = victim_of(lv);
            model_miss = sat(model_miss);
            if (dv[v]) push(1, v, wr, 1'b0);
            push(2, v, wr, withdraw);
            if (!withdraw) push(0, v, wr, 1'b1);
        end
        arb_write = wr;
        arb_read  = !wr || rd_too;
        hit       = hv;
        dirty     = dv;
        LRU_out   = lv;
        tick();
        if (hv == 4'd0) begin
            phases = dv[v] ? 2 : 1;
            for (int p = 0; p < phases; p++) begin
                for (int c = 0; c < dly; c++) begin
                    hit     = 4'($urandom);
                    dirty   = 4'($urandom);
                    LRU_out = 3'($urandom);
                    tick();
                end
                if (withdraw && p == phases - 1) begin
                    arb_read  = 1'b0;
                    arb_write = 1'b0;
                end
                n = 0;
                while (!(pmem_read || pmem_write) && n < 20) begin
                    tick();
                    n++;
                end
                if (n >= 20) begin
                    check("pmem_req_timeout", 1'b0, "no pmem request within 20 cycles, required one");
                    timed_out = 1'b1;
                    break;
                end
                LRU_out   = 3'($urandom);
                pmem_resp = 1'b1;
                if (p == phases - 1) hit = 4'b0001 << v;
                tick();
                pmem_resp = 1'b0;
            end
            if (timed_out) begin
                resync();
                return;
            end
            if (!withdraw) tick();
        end
        arb_read  = 1'b0;
        arb_write = 1'b0;
        for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
            hit       = 4'($urandom);
            pmem_resp = 1'($urandom);
            tick();
        end
        pmem_resp = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; arb_read = 1'b0; arb_write = 1'b0; hit = 4'd0; dirty = 4'd0;
        LRU_out = 3'd0; pmem_resp = 1'b0; clr_stats = 1'b0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", !pmem_read && !pmem_write && !write_back_bit && !arb_resp &&
              !load_data && hit_count == '0 && miss_count == '0,
              $sformatf("pr=%0b pw=%0b wbb=%0b hc=%0d mc=%0d required all 0",
                        pmem_read, pmem_write, write_back_bit, hit_count, miss_count));
        tick();
        mon_en = 1'b1;

        // Read hit on way 2, clean miss on way 1, dirty write miss on way 3
        do_txn(1'b0, 1'b0, 4'b0100, 4'b0000, 3'b000, 1'b0, 0);
        do_txn(1'b0, 1'b0, 4'b0000, 4'b0000, 3'b010, 1'b0, 5);
        do_txn(1'b1, 1'b0, 4'b0000, 4'b1000, 3'b101, 1'b0, 2);
        // Multi-hit priority and read+write treated as write
        do_txn(1'b1, 1'b1, 4'b1010, 4'b0000, 3'b111, 1'b0, 0);
        // Request withdrawn mid-miss
        do_txn(1'b0, 1'b0, 4'b0000, 4'b0100, 3'b011, 1'b1, 1);
        do_txn(1'b0, 1'b0, 4'b1000, 4'b0000, 3'b000, 1'b0, 0);

        // Reset in ALLOCATE abandons the fill
        arb_read = 1'b1; hit = 4'd0; dirty = 4'd0; LRU_out = 3'b110;
        tick();
        @(negedge clk);
        check("alloc_before_reset", pmem_read && way_sel == 2'd1,
              $sformatf("pmem_read=%0b way=%0d required 1/1", pmem_read, way_sel));
        tick();
        arb_read = 1'b0;
        reset    = 1'b1;
        tick();
        reset      = 1'b0;
        model_hit  = '0;
        model_miss = '0;
        @(negedge clk);
        check("after_reset", !pmem_read && !pmem_write && !write_back_bit &&
              hit_count == '0 && miss_count == '0,
              $sformatf("pr=%0b pw=%0b wbb=%0b hc=%0d mc=%0d required all 0",
                        pmem_read, pmem_write, write_back_bit, hit_count, miss_count));
        tick();
        do_txn(1'b1, 1'b0, 4'b0000, 4'b0001, 3'b000, 1'b0, 3);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [3:0] hv;
            bit         wr;
            wr = 1'($urandom);
            hv = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            do_txn(wr, 1'($urandom), hv, 4'($urandom), 3'($urandom),
                   (hv == 4'd0) && ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)));
        end

        // Statistics clear, hit saturation, clear beating a concurrent hit
        repeat (3) tick();
        mon_en    = 1'b0;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        @(negedge clk);
        check("clr_stats", hit_count == '0 && miss_count == '0,
              $sformatf("hc=%0d mc=%0d required 0/0", hit_count, miss_count));
        tick();
        arb_read = 1'b1; hit = 4'b0001;
        repeat (int'(CMAX) + 3) @(posedge clk);
        #1;
        @(negedge clk);
        check("hit_saturate", hit_count == CMAX,
              $sformatf("hit_count=%0h required %0h", hit_count, CMAX));
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        arb_read  = 1'b0;
        @(negedge clk);
        check("clr_vs_hit", hit_count == '0 && miss_count == '0,
              $sformatf("hc=%0d mc=%0d required 0/0", hit_count, miss_count));

        tick(); tick();
        check("queue_drained", q.size() == 0,
              $sformatf("%0d expected events left, required 0", q.size()));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
